alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Initiator side of the RISCALU operand interface.
- Accepts one 32-bit RV32I OP or OP-IMM instruction per valid/ready handshake and decodes it.
- Reads source registers from an internal register file, drives funct3/funct7/s1/s2 to the registered ALU, then writes the ALU result back to rd.
- Sits between instruction fetch and the ALU. It also reports illegal encodings and the ALU zero flag.

Parameters:
- XLEN, 32: datapath width. Only 32 is supported.
- NUM_REGS, 32: register file depth. x0 is hardwired to zero.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- instr_valid  in  1  instr is valid this cycle.
- instr  in  32  RV32I instruction.
- instr_ready  out  1  block can accept an instruction.
- alu_funct3  out  3  to ALU funct3.
- alu_funct7  out  7  to ALU funct7.
- alu_s1  out  32  to ALU s1.
- alu_s2  out  32  to ALU s2.
- alu_d  in  32  ALU registered result.
- alu_zero  in  1  ALU zero flag.
- wb_valid  out  1  one-cycle pulse: rd written this cycle.
- wb_rd  out  5  destination register of the writeback.
- wb_data  out  32  value written.
- wb_zero  out  1  alu_zero captured at writeback.
- illegal  out  1  one-cycle pulse: instruction rejected.
- dbg_addr  in  5  debug register-read address.
- dbg_data  out  32  combinational read of regfile[dbg_addr]; reads 0 when dbg_addr is 0.

Behaviour:
- Reset: synchronous, active-low, sampled on the rising edge of clk.
  - On reset: state=IDLE; all 32 registers=0.
  - alu_funct3/alu_funct7/alu_s1/alu_s2=0.
  - wb_valid=0, wb_rd=0, wb_data=0, wb_zero=0, illegal=0.
  - instr_ready=1 on the first cycle after reset.
- Reset mid-operation aborts the instruction: no writeback and no illegal pulse.
- FSM states: IDLE -> DECODE -> EXEC -> WB -> IDLE.
  - IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr and go to DECODE. No accept in any other state (instr_ready=0).
  - DECODE: classify the latched instruction and read rs1/rs2.
    - Legal: register the ALU outputs, go to EXEC.
    - Illegal: pulse illegal for one cycle, go to IDLE. Regfile and ALU outputs are unchanged.
  - EXEC: ALU outputs held stable; the ALU captures on this cycle's closing edge. Go to WB.
  - WB: alu_d is valid. Write regfile[rd]=alu_d unless rd=0. Pulse wb_valid with wb_rd=rd, wb_data=alu_d, wb_zero=alu_zero. Go to IDLE.
- ALU outputs hold their last values in IDLE/DECODE/WB; they change only on the DECODE->EXEC transition.
- Latency: accept at edge N; wb_valid high in cycle N+3; instr_ready high again in cycle N+4. Maximum rate is one instruction per 4 cycles.
- Legal R-type (opcode 7'b0110011):
  - funct7=0x00 with any funct3.
  - funct7=0x20 with funct3=5 (SRA).
  - All other funct7/funct3 combinations are illegal, including SUB (funct3=0, funct7=0x20), because the ALU has no subtract.
  - s1=rs1 value, s2=rs2 value, alu_funct7=instr[31:25].
- Legal I-type (opcode 7'b0010011):
  - s1=rs1 value, s2=sign-extended instr[31:20].
  - alu_funct7=0x00, except for shifts.
  - Shifts (funct3=1 or 5): s2={27'b0, instr[24:20]}, alu_funct7=instr[31:25].
  - funct3=1 requires instr[31:25]=0x00; funct3=5 requires 0x00 or 0x20. Anything else is illegal.
- Any other opcode is illegal.
- Shift masking: for funct3=1 or 5 in both formats, alu_s2[31:5] is forced to 0. This gives the RV32I 5-bit shift amount.
- rd=0: wb_valid still pulses with wb_rd=0 and wb_data=alu_d. The regfile is not written and x0 still reads 0.
- Operands are read in DECODE, so a result is visible to the next accepted instruction; no forwarding is needed.
- instr_valid is ignored whenever instr_ready=0. The instruction is not queued.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093) -> alu_funct3=0, s1=0, s2=5 in EXEC; wb_valid at accept+3 with wb_rd=1, wb_data=5, wb_zero=0; dbg_data(1)=5.
- x1=5, ADDI x2,x1,-5 -> s2=0xFFFFFFFB; wb_data=0, wb_zero=1, x2=0.
- x1=0x80000000, x3=0x00000024, SRA x4,x1,x3 -> alu_funct7=0x20, alu_s2=4 (masked); x4=0xF8000000.
- SUB x5,x1,x2 (funct7=0x20, funct3=0), then opcode 0x63 -> each gives an illegal pulse one cycle after accept, no wb_valid, x5 unchanged, instr_ready back two cycles after accept.
- ADDI x0,x0,7 -> wb_valid with wb_rd=0, wb_data=7; dbg_data(0)=0. Hold instr_valid high continuously -> accepts exactly every 4th cycle.
- Accept ADDI x6,x0,9, drive rst_n=0 during EXEC -> no wb_valid; x6=0; all outputs 0 after reset; instr_ready=1.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the registered RISCALU: accepts one RV32I OP/OP-IMM
// instruction, reads operands from the local regfile, drives the ALU, writes back.
//
// state  | meaning
// IDLE   | instr_ready high, waiting for a handshake
// DECODE | classify latched instruction, read rs1/rs2, pulse illegal if rejected
// EXEC   | ALU operands stable, ALU captures on the closing edge
// WB     | alu_d valid, write rd, pulse wb_valid
module alu_issue_ctrl #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic [2:0]      alu_funct3,
  output logic [6:0]      alu_funct7,
  output logic [XLEN-1:0] alu_s1,
  output logic [XLEN-1:0] alu_s2,
  input  logic [XLEN-1:0] alu_d,
  input  logic            alu_zero,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_zero,
  output logic            illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO    = 7'h00;
  localparam logic [6:0] F7_ALT     = 7'h20;

  state_t            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [6:0]        funct7_q, funct7_d;
  logic [XLEN-1:0]   s1_q, s1_d;
  logic [XLEN-1:0]   s2_q, s2_d;
  logic [XLEN-1:0]   regs_q [NUM_REGS];

  logic [6:0]        dec_opcode;
  logic [4:0]        dec_rd;
  logic [2:0]        dec_f3;
  logic [4:0]        dec_rs1;
  logic [4:0]        dec_rs2;
  logic [6:0]        dec_f7;
  logic              dec_legal;
  logic              dec_is_shift;
  logic [6:0]        dec_alu_f7;
  logic [XLEN-1:0]   dec_s2_raw;
  logic [XLEN-1:0]   dec_s2;
  logic [XLEN-1:0]   rs1_val;
  logic [XLEN-1:0]   rs2_val;
  logic              accept;

  assign dec_opcode   = instr_q[6:0];
  assign dec_rd       = instr_q[11:7];
  assign dec_f3       = instr_q[14:12];
  assign dec_rs1      = instr_q[19:15];
  assign dec_rs2      = instr_q[24:20];
  assign dec_f7       = instr_q[31:25];
  assign dec_is_shift = (dec_f3 == 3'd1) || (dec_f3 == 3'd5);

  assign rs1_val  = (dec_rs1 == 5'd0)  ? '0 : regs_q[dec_rs1];
  assign rs2_val  = (dec_rs2 == 5'd0)  ? '0 : regs_q[dec_rs2];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];

  assign accept = (state_q == S_IDLE) && instr_valid;

  // Instruction classification and operand-2 selection
  always_comb begin
    dec_legal  = 1'b0;
    dec_alu_f7 = F7_ZERO;
    dec_s2_raw = '0;
    unique case (dec_opcode)
      OPC_OP: begin
        dec_legal  = (dec_f7 == F7_ZERO) ||
                     ((dec_f7 == F7_ALT) && (dec_f3 == 3'd5));
        dec_alu_f7 = dec_f7;
        dec_s2_raw = rs2_val;
      end
      OPC_OP_IMM: begin
        if (dec_f3 == 3'd1) begin
          dec_legal  = (dec_f7 == F7_ZERO);
          dec_alu_f7 = dec_f7;
          dec_s2_raw = {{(XLEN-5){1'b0}}, dec_rs2};
        end else if (dec_f3 == 3'd5) begin
          dec_legal  = (dec_f7 == F7_ZERO) || (dec_f7 == F7_ALT);
          dec_alu_f7 = dec_f7;
          dec_s2_raw = {{(XLEN-5){1'b0}}, dec_rs2};
        end else begin
          dec_legal  = 1'b1;
          dec_alu_f7 = F7_ZERO;
          dec_s2_raw = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
        end
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

  // Shifts only ever see a 5-bit amount, whichever format supplied it
  assign dec_s2 = dec_is_shift ? {{(XLEN-5){1'b0}}, dec_s2_raw[4:0]} : dec_s2_raw;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (instr_valid) state_d = S_DECODE;
      S_DECODE: state_d = dec_legal ? S_EXEC : S_IDLE;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state_q == S_IDLE);
    illegal     = (state_q == S_DECODE) && !dec_legal;
    wb_valid    = (state_q == S_WB);
    wb_rd       = (state_q == S_WB) ? dec_rd : 5'd0;
    wb_data     = (state_q == S_WB) ? alu_d  : '0;
    wb_zero     = (state_q == S_WB) && alu_zero;
  end

  always_comb begin
    instr_d  = instr_q;
    funct3_d = funct3_q;
    funct7_d = funct7_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    if (accept) begin
      instr_d = instr;
    end
    if ((state_q == S_DECODE) && dec_legal) begin
      funct3_d = dec_f3;
      funct7_d = dec_alu_f7;
      s1_d     = rs1_val;
      s2_d     = dec_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q  <= '0;
      funct3_q <= '0;
      funct7_q <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      instr_q  <= instr_d;
      funct3_q <= funct3_d;
      funct7_q <= funct7_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
    end
  end

  // x0 is never written, so its storage stays at the reset value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if ((state_q == S_WB) && (dec_rd != 5'd0)) begin
      regs_q[dec_rd] <= alu_d;
    end
  end

  assign alu_funct3 = funct3_q;
  assign alu_funct7 = funct7_q;
  assign alu_s1     = s1_q;
  assign alu_s2     = s2_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed test-plan steps plus random OP/OP-IMM
// traffic, checked against an instruction-level reference model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic [31:0] alu_s1, alu_s2;
  logic [31:0] alu_d = '0;
  logic        alu_zero = 1'b0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_zero;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mregs [32];
  logic [2:0]  last_f3;
  logic [6:0]  last_f7;
  logic [31:0] last_s1, last_s2;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.XLEN(32), .NUM_REGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_s1(alu_s1), .alu_s2(alu_s2), .alu_d(alu_d), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_zero(wb_zero),
    .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Registered ALU on the far side of the interface
  function automatic logic [31:0] alu_fn(input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return f7[5] ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  always @(posedge clk) begin
    alu_d    <= alu_fn(alu_funct3, alu_funct7, alu_s1, alu_s2);
    alu_zero <= (alu_fn(alu_funct3, alu_funct7, alu_s1, alu_s2) == 32'd0);
  end

  // Reference: what an RV32I core would do with this instruction, given the ISA subset
  function automatic void ref_exec(input logic [31:0] ins, output logic lg,
                                   output logic [2:0] f3o, output logic [6:0] f7o,
                                   output logic [31:0] s1o, output logic [31:0] s2o,
                                   output logic [31:0] res);
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b;
    int          sh;
    f3  = ins[14:12];
    f7  = ins[31:25];
    a   = mregs[ins[19:15]];
    b   = 0;
    lg  = 1'b0;
    f7o = 7'h00;
    if (ins[6:0] == 7'h33) begin
      b   = mregs[ins[24:20]];
      lg  = (f7 == 7'h00) || (f7 == 7'h20 && f3 == 3'd5);
      f7o = f7;
    end else if (ins[6:0] == 7'h13) begin
      if (f3 == 3'd1 || f3 == 3'd5) begin
        b   = 32'(ins[24:20]);
        lg  = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
        f7o = f7;
      end else begin
        b  = 32'($signed(ins[31:20]));
        lg = 1'b1;
      end
    end
    if (f3 == 3'd1 || f3 == 3'd5) b = b % 32;
    sh  = int'(b % 32);
    f3o = f3;
    s1o = a;
    s2o = b;
    case (f3)
      3'd0: res = a + b;
      3'd1: res = a * (32'd1 << sh);
      3'd2: res = (int'(a) < int'(b)) ? 1 : 0;
      3'd3: res = (a < b) ? 1 : 0;
      3'd4: res = a ^ b;
      3'd5: res = f7[5] ? 32'(int'(a) >>> sh) : a / (32'd1 << sh);
      3'd6: res = a | b;
      default: res = a & b;
    endcase
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input logic [4:0] a);
    dbg_addr = a;
    #1;
    chk($sformatf("dbg_x%0d", a), dbg_data, mregs[a]);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, 32'(instr_ready), 32'd1);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_wb_zero"}, 32'(wb_zero), 32'd0);
    chk({tag, "_illegal"}, 32'(illegal), 32'd0);
    chk({tag, "_f3"}, 32'(alu_funct3), 32'(last_f3));
    chk({tag, "_f7"}, 32'(alu_funct7), 32'(last_f7));
    chk({tag, "_s1"}, alu_s1, last_s1);
    chk({tag, "_s2"}, alu_s2, last_s2);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    last_f3 = '0;
    last_f7 = '0;
    last_s1 = '0;
    last_s2 = '0;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!instr_ready && w < 10) begin
      tick();
      w++;
    end
    chk("ready_wait", 32'(instr_ready), 32'd1);
  endtask

  task automatic run_instr(input logic [31:0] ins);
    logic        lg;
    logic [2:0]  ef3;
    logic [6:0]  ef7;
    logic [31:0] es1, es2, eres;
    logic [4:0]  rd;
    rd = ins[11:7];
    wait_ready();
    ref_exec(ins, lg, ef3, ef7, es1, es2, eres);
    instr       = ins;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instr       = $urandom;
    chk("decode_ready", 32'(instr_ready), 32'd0);
    chk("decode_illegal", 32'(illegal), 32'(!lg));
    chk("decode_wb_valid", 32'(wb_valid), 32'd0);
    if (!lg) begin
      tick();
      chk_idle_outputs("after_illegal");
    end else begin
      tick();
      chk("exec_f3", 32'(alu_funct3), 32'(ef3));
      chk("exec_f7", 32'(alu_funct7), 32'(ef7));
      chk("exec_s1", alu_s1, es1);
      chk("exec_s2", alu_s2, es2);
      chk("exec_wb_valid", 32'(wb_valid), 32'd0);
      tick();
      chk("wb_valid", 32'(wb_valid), 32'd1);
      chk("wb_rd", 32'(wb_rd), 32'(rd));
      chk("wb_data", wb_data, eres);
      chk("wb_zero", 32'(wb_zero), 32'(eres == 32'd0));
      chk("wb_ready", 32'(instr_ready), 32'd0);
      tick();
      if (rd != 5'd0) mregs[rd] = eres;
      last_f3 = ef3;
      last_f7 = ef7;
      last_s1 = es1;
      last_s2 = es2;
      chk_idle_outputs("after_wb");
    end
    chk_reg(rd);
    chk_reg(5'($urandom_range(0, 31)));
  endtask

  function automatic logic [31:0] rand_instr();
    int          sel;
    int          f7sel;
    logic [6:0]  f7;
    logic [31:0] ins;
    sel   = $urandom_range(0, 9);
    f7sel = $urandom_range(0, 3);
    f7    = (f7sel == 2) ? 7'h20 : (f7sel == 3) ? 7'($urandom) : 7'h00;
    ins   = $urandom;
    if (sel <= 4) begin
      ins[6:0] = 7'h13;
      if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) ins[31:25] = f7;
    end else if (sel <= 8) begin
      ins[6:0]   = 7'h33;
      ins[31:25] = f7;
    end else if (ins[6:0] == 7'h13 || ins[6:0] == 7'h33) begin
      ins[0] = ~ins[0];
    end
    return ins;
  endfunction

  initial begin
    int accepts;
    int prev;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    dbg_addr    = '0;
    model_reset();
    tick();
    tick();
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    chk("reset_ready", 32'(instr_ready), 32'd1);
    chk_reg(5'd1);
    chk_reg(5'd31);

    run_instr(32'h00500093);
    chk("addi_x1", mregs[1], 32'd5);
    run_instr(enc_i(12'hFFB, 5'd1, 3'd0, 5'd2));
    run_instr(enc_i(12'd1, 5'd0, 3'd0, 5'd1));
    run_instr(enc_i({7'h00, 5'd31}, 5'd1, 3'd1, 5'd1));
    run_instr(enc_i(12'h024, 5'd0, 3'd0, 5'd3));
    run_instr(enc_r(7'h20, 5'd3, 5'd1, 3'd5, 5'd4));
    run_instr(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd5));
    run_instr({7'h00, 5'd2, 5'd1, 3'd0, 5'd5, 7'h63});
    chk_reg(5'd5);
    run_instr(enc_i(12'd7, 5'd0, 3'd0, 5'd0));
    run_instr(enc_i({7'h20, 5'd3}, 5'd4, 3'd5, 5'd8));
    run_instr(enc_i({7'h01, 5'd3}, 5'd4, 3'd1, 5'd9));

    // Back-to-back: valid held high, ADDI x7,x7,1 accepted every 4th cycle
    wait_ready();
    instr       = enc_i(12'd1, 5'd7, 3'd0, 5'd7);
    instr_valid = 1'b1;
    accepts     = 0;
    prev        = -4;
    for (int c = 0; c < 16; c++) begin
      if (instr_ready) begin
        accepts++;
        chk("accept_gap", 32'(c - prev), 32'd4);
        prev = c;
      end
      tick();
    end
    instr_valid = 1'b0;
    chk("accept_count", 32'(accepts), 32'd4);
    mregs[7] = mregs[7] + 32'd4;
    last_f3  = 3'd0;
    last_f7  = 7'h00;
    last_s1  = mregs[7] - 32'd1;
    last_s2  = 32'd1;
    chk_idle_outputs("b2b_end");
    chk_reg(5'd7);

    for (int i = 0; i < 60; i++) run_instr(rand_instr());

    // Reset while an instruction is in EXEC aborts it
    wait_ready();
    instr       = enc_i(12'd9, 5'd0, 3'd0, 5'd6);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    model_reset();
    chk_idle_outputs("mid_reset");
    rst_n = 1'b1;
    chk_reg(5'd6);
    chk_reg(5'd1);
    tick();
    chk_idle_outputs("post_reset");
    run_instr(32'h00500093);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
